// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative 8-bit binary to 3-digit BCD converter (double dabble).
// The digit outputs only update on the final load cycle, so a downstream
// display scanner never sees partially converted values.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2
);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t      state_q, state_d;
  logic [7:0]  sh_bin_q, sh_bin_d;
  logic [11:0] sh_bcd_q, sh_bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] dig_q, dig_d;
  logic        done_q, done_d;
  logic [11:0] bcd_corr;

  // Add-3 correction applied per nibble; no carry crosses nibble boundaries.
  always_comb begin
    bcd_corr = sh_bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (sh_bcd_q[4*i +: 4] >= 4'd5)
        bcd_corr[4*i +: 4] = sh_bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Next-state and datapath control for the IDLE -> SHIFT x8 -> LOAD sequence.
  always_comb begin
    state_d  = state_q;
    sh_bin_d = sh_bin_q;
    sh_bcd_d = sh_bcd_q;
    cnt_d    = cnt_q;
    dig_d    = dig_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sh_bin_d = bin;
          sh_bcd_d = 12'd0;
          cnt_d    = 4'd0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // Binary MSB shifts into the BCD LSB; correction precedes each shift,
        // so nothing is corrected after the eighth shift.
        sh_bcd_d = {bcd_corr[10:0], sh_bin_q[7]};
        sh_bin_d = {sh_bin_q[6:0], 1'b0};
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'd7) state_d = LOAD;
      end
      LOAD: begin
        dig_d   = sh_bcd_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sh_bin_q <= 8'd0;
      sh_bcd_q <= 12'd0;
      cnt_q    <= 4'd0;
      dig_q    <= 12'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_bin_q <= sh_bin_d;
      sh_bcd_q <= sh_bcd_d;
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign digit2 = dig_q[11:8];
  assign digit1 = dig_q[7:4];
  assign digit0 = dig_q[3:0];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, handshake corner cases,
// exhaustive sweep and random values against an arithmetic reference.
module tb_bin2bcd_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] bin;
  logic       busy, done;
  logic [3:0] digit0, digit1, digit2;

  int n_pass = 0;
  int n_tot  = 0;
  // Last result the display should be showing.
  int prev_d2 = 0, prev_d1 = 0, prev_d0 = 0;

  typedef struct {
    logic [7:0] v;
    int         d2, d1, d0;
  } vec_t;

  bin2bcd_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done),
    .digit0(digit0), .digit1(digit1), .digit2(digit2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dig_val();
    return 100 * int'(digit2) + 10 * int'(digit1) + int'(digit0);
  endfunction

  // Called just after the accepting edge; waits for done and checks timing.
  task automatic wait_done(input string tag);
    int n;
    bit bad;
    n = 1;
    bad = 0;
    while (done !== 1'b1 && n < 20) begin
      if (busy !== 1'b1 || digit2 != prev_d2 || digit1 != prev_d1 || digit0 != prev_d0)
        bad = 1;
      tick();
      n++;
    end
    chk({tag, " done cycle"}, n, 10);
    chk({tag, " busy/hold before done"}, int'(bad), 0);
    chk({tag, " busy in done cycle"}, int'(busy), 0);
  endtask

  task automatic check_digits(input string tag, input int d2, input int d1, input int d0);
    chk({tag, " value"}, dig_val(), 100 * d2 + 10 * d1 + d0);
    prev_d2 = d2; prev_d1 = d1; prev_d0 = d0;
  endtask

  task automatic convert(input logic [7:0] v, input string tag);
    start = 1'b1;
    bin   = v;
    tick();
    start = 1'b0;
    bin   = ~v;
    wait_done(tag);
    check_digits(tag, int'(v) / 100, (int'(v) / 10) % 10, int'(v) % 10);
  endtask

  initial begin
    vec_t vt[6];
    int   first_done, n_done;
    bit   bad;
    logic [7:0] r;

    vt[0] = '{8'd255, 2, 5, 5};
    vt[1] = '{8'd0,   0, 0, 0};
    vt[2] = '{8'd109, 1, 0, 9};
    vt[3] = '{8'd200, 2, 0, 0};
    vt[4] = '{8'd99,  0, 9, 9};
    vt[5] = '{8'd10,  0, 1, 0};

    // Reset held with start asserted: outputs stay quiet.
    rst_n = 1'b0; start = 1'b1; bin = 8'd255;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset digits", dig_val(), 0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0 || dig_val() != 0) bad = 1;
    end
    chk("idle after reset", int'(bad), 0);

    // Table vectors with hand-computed digits.
    for (int i = 0; i < 6; i++) begin
      start = 1'b1;
      bin   = vt[i].v;
      tick();
      start = 1'b0;
      wait_done($sformatf("vec%0d", i));
      chk($sformatf("vec%0d d2", i), int'(digit2), vt[i].d2);
      chk($sformatf("vec%0d d1", i), int'(digit1), vt[i].d1);
      chk($sformatf("vec%0d d0", i), int'(digit0), vt[i].d0);
      prev_d2 = vt[i].d2; prev_d1 = vt[i].d1; prev_d0 = vt[i].d0;
      tick();
      chk($sformatf("vec%0d done single", i), int'(done), 0);
      chk($sformatf("vec%0d hold", i), dig_val(), int'(vt[i].v));
    end

    // Handshake abuse: start/bin wiggled mid-conversion of 123.
    start = 1'b1; bin = 8'd123;
    tick();
    start = 1'b0;
    first_done = 0; n_done = 0;
    for (int n = 1; n <= 25; n++) begin
      if (n == 3) begin start = 1'b1; bin = 8'd7; end
      if (n == 4) begin start = 1'b0; bin = 8'd99; end
      if (done === 1'b1) begin
        n_done++;
        if (first_done == 0) begin
          first_done = n;
          chk("abuse value", dig_val(), 123);
        end
      end
      if (n > 11 && busy !== 1'b0) bad = 1;
      tick();
    end
    chk("abuse done cycle", first_done, 10);
    chk("abuse done count", n_done, 1);
    chk("abuse no restart", int'(busy), 0);
    prev_d2 = 1; prev_d1 = 2; prev_d0 = 3;

    // Back-to-back: 42 accepted in the done cycle of 17.
    start = 1'b1; bin = 8'd17;
    tick();
    start = 1'b0;
    wait_done("b2b 17");
    check_digits("b2b 17", 0, 1, 7);
    start = 1'b1; bin = 8'd42;
    tick();
    start = 1'b0;
    chk("b2b done drops", int'(done), 0);
    chk("b2b busy", int'(busy), 1);
    wait_done("b2b 42");
    check_digits("b2b 42", 0, 4, 2);

    // Reset abort at E4 of an 88 conversion.
    start = 1'b1; bin = 8'd88;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort digits", dig_val(), 0);
    chk("abort busy", int'(busy), 0);
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    chk("abort no done", n_done, 0);
    prev_d2 = 0; prev_d1 = 0; prev_d0 = 0;

    // Exhaustive sweep with digit range checks.
    bad = 0;
    for (int v = 0; v < 256; v++) begin
      convert(8'(v), $sformatf("sweep %0d", v));
      if (digit0 > 9 || digit1 > 9 || digit2 > 2) bad = 1;
    end
    chk("sweep digit ranges", int'(bad), 0);

    // Random values, random idle gaps.
    for (int i = 0; i < 40; i++) begin
      r = 8'($urandom_range(255));
      repeat ($urandom_range(2)) tick();
      convert(r, $sformatf("rand %0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential 8-bit binary to 3-digit BCD converter using an iterative shift-and-add-3 (double-dabble) algorithm. It sits directly upstream of the 3-digit seven-segment scanner: its `digit0`/`digit1`/`digit2` outputs drive the scanner's digit inputs (ones, tens, hundreds). It uses a start/busy/done handshake. Outputs hold the last completed result so the display never shows intermediate values.

## Interface
Parameters:
- None. The input width is fixed at 8 bits and the output at 3 BCD digits; the maximum value 255 always fits.

Ports:
- `clk` in 1: system clock. The whole design is in this single domain.
- `rst_n` in 1: reset, synchronous, active-low. Sampled only on the rising edge of `clk`.
- `start` in 1: request a conversion. Sampled only while `busy`=0.
- `bin` in 8: unsigned binary value. Captured on the edge that accepts `start`.
- `busy` out 1: conversion in progress.
- `done` out 1: single-cycle pulse marking that the digit outputs now hold the new result.
- `digit0` out 4: BCD ones digit.
- `digit1` out 4: BCD tens digit.
- `digit2` out 4: BCD hundreds digit, range 0–2.

## Operation
- Internal state:
  - FSM states IDLE, SHIFT and LOAD.
  - 8-bit binary shift register `sh_bin`.
  - 12-bit BCD scratch `sh_bcd`.
  - 4-bit shift counter `cnt` (0–8).
- Reset, on any edge with `rst_n`=0:
  - state goes to IDLE;
  - `sh_bin`, `sh_bcd` and `cnt` clear to 0;
  - `busy`, `done`, `digit0`, `digit1` and `digit2` go to 0.
  - Reset takes priority over everything, including mid-conversion.
- IDLE:
  - `busy`=0.
  - When `start`=1:
    - `sh_bin` takes `bin`;
    - `sh_bcd` and `cnt` clear to 0;
    - state goes to SHIFT.
- SHIFT, one iteration per cycle:
  - Correct: for each nibble of `sh_bcd` whose value is 5 or more, add 3 to that nibble. Nibbles are corrected independently; the add is 4-bit with no carry between nibbles.
  - Shift: shift the concatenation {corrected `sh_bcd`, `sh_bin`} left by 1. The MSB of `sh_bin` moves into the LSB of `sh_bcd`.
  - `cnt` increments.
  - When `cnt` reaches 8 after the increment, state goes to LOAD.
  - No add-3 is applied after the 8th shift.
- LOAD, lasting one cycle:
  - `digit2` takes `sh_bcd[11:8]`, `digit1` takes `sh_bcd[7:4]`, `digit0` takes `sh_bcd[3:0]`.
  - `done` is registered to 1.
  - State goes to IDLE.
- `busy`=1 exactly while the state is SHIFT or LOAD. It is driven from registered state, not from `start`.
- `start` is ignored while `busy`=1. There is no queuing.
- `bin` is ignored at all times except the accepting edge. Changes during a conversion do not affect the result.
- Digit outputs change only on the LOAD edge and hold between conversions.

## Timing
- Edge E0: `start`=1 while IDLE.
  - State becomes SHIFT.
  - `busy`=1 from the cycle after E0.
- Edges E1 through E8: the eight shift iterations.
  - State becomes LOAD after E8.
- Edge E9:
  - New digits become visible.
  - `done`=1 for exactly the one cycle after E9.
  - `busy`=0 in that same cycle.
- Latency from `start` sampled to `done` is 9 clocks. The throughput limit is one conversion per 9 clocks.
- Back-to-back operation:
  - `start`=1 during the `done` cycle is accepted, because the state is IDLE.
  - That edge becomes the new E0.
  - `done` still drops to 0 on that edge.
- Reset mid-conversion:
  - The conversion is aborted.
  - No `done` pulse is produced.
  - Digits read 0 after the reset edge.
  - `start` may be accepted on the first edge with `rst_n`=1.
- `done` never stays high for two consecutive cycles.

## Test plan
- Reset, then idle:
  - Hold `rst_n`=0 for 3 clocks with `start`=1.
  - Required: `busy`=0, `done`=0 and all digits 0 throughout.
  - After release with `start`=0: outputs remain unchanged.
- Basic conversion of 255:
  - Apply `bin`=8'd255 with a single-cycle `start`.
  - Required:
    - `busy` high for 9 cycles;
    - `done` pulses in cycle 10 after the accepting edge;
    - digit2/digit1/digit0 = 2/5/5;
    - digits hold afterwards.
- Values 0, 109 and 200:
  - Convert each in turn.
  - Required outputs: 0/0/0, then 1/0/9, then 2/0/0.
  - Digits must not change before each `done` pulse.
- Handshake abuse:
  - Start a conversion of 123.
  - Mid-conversion, pulse `start` with `bin`=7 and also change `bin` to 99.
  - Required: result 1/2/3, a single `done`, and no second conversion.
- Back-to-back and reset-abort:
  - Assert `start` with `bin`=42 in the `done` cycle of a 17 conversion.
  - Required: 0/1/7, then 0/4/2 nine clocks later.
  - Then start a conversion of 88 and drive `rst_n`=0 at E4.
  - Required: no `done` pulse, and digits equal to 0.
- Exhaustive sweep:
  - Convert every value from 0 to 255.
  - Required: 100×digit2 + 10×digit1 + digit0 equals `bin`.
  - Required: every digit is at most 9, and digit2 is at most 2.
